// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the write-back data cache.
package dcache_pkg;

    localparam int ADDR_W   = 8;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W  = 32;
    localparam int BLK_A_W  = ADDR_W - OFFSET_W;
    localparam int NBLK     = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_W-1:0]   tag;
        logic [BLOCK_W-1:0] data;
    } line_t;

    function automatic logic [7:0] get_byte(
        input logic [BLOCK_W-1:0]  blk,
        input logic [OFFSET_W-1:0] off
    );
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage, combinational read by index,
// synchronous byte or whole-block write, RESET clears valid and dirty only.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [INDEX_W-1:0]  rd_idx,
    output line_t               rd_line,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic                byte_we,
    input  logic [OFFSET_W-1:0] wr_off,
    input  logic [7:0]          wr_byte,
    input  logic                blk_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_blk
);

    logic [NBLK-1:0]    valid;
    logic [NBLK-1:0]    dirty;
    logic [TAG_W-1:0]   tag  [NBLK];
    logic [BLOCK_W-1:0] data [NBLK];

    always_comb begin
        rd_line.valid = valid[rd_idx];
        rd_line.dirty = dirty[rd_idx];
        rd_line.tag   = tag[rd_idx];
        rd_line.data  = data[rd_idx];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (blk_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
        end else if (byte_we) begin
            dirty[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are ignored while valid is clear.
    always_ff @(posedge CLK) begin
        if (blk_we) begin
            tag[wr_idx]  <= wr_tag;
            data[wr_idx] <= wr_blk;
        end else if (byte_we) begin
            data[wr_idx][{wr_off, 3'b000} +: 8] <= wr_byte;
        end
    end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back/write-allocate data cache with miss FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_wb
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [7:0]         WRITEDATA,
    output logic [7:0]         READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [BLK_A_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]        HIT_COUNT,
    output logic [15:0]        MISS_COUNT
`endif
);

    state_t             state;
    state_t             state_nx;
    line_t              line;
    logic               req;
    logic               idle;
    logic               hit;
    logic               byte_we;
    logic               blk_we;
    logic [BLK_A_W-1:0] blk_addr;
    logic [BLK_A_W-1:0] miss_q;
    logic [BLOCK_W-1:0] fill_q;
    logic [INDEX_W-1:0] idx;

    assign req  = READ | WRITE;
    assign idle = (state == IDLE);

    // Outside IDLE the block address is frozen so a dropped request
    // cannot redirect a miss that is already in flight.
    assign blk_addr = idle ? ADDRESS[ADDR_W-1:OFFSET_W] : miss_q;
    assign idx      = blk_addr[INDEX_W-1:0];

    assign hit     = line.valid & (line.tag == ADDRESS[ADDR_W-1 -: TAG_W]);
    assign byte_we = WRITE & idle & hit;
    assign blk_we  = (state == UPDATE);

    assign BUSYWAIT = req & ~(idle & hit);
    assign READDATA = READ ? get_byte(line.data, ADDRESS[OFFSET_W-1:0])
                           : 8'h00;

    dcache_array u_array (
        .CLK     (CLK),
        .RESET   (RESET),
        .rd_idx  (idx),
        .rd_line (line),
        .wr_idx  (idx),
        .byte_we (byte_we),
        .wr_off  (ADDRESS[OFFSET_W-1:0]),
        .wr_byte (WRITEDATA),
        .blk_we  (blk_we),
        .wr_tag  (blk_addr[BLK_A_W-1 -: TAG_W]),
        .wr_blk  (fill_q)
    );

    always_comb begin
        state_nx      = state;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = blk_addr;
        MEM_WRITEDATA = line.data;
        unique case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nx = (line.valid && line.dirty) ? WRITEBACK
                                                          : FETCH;
                end
            end
            WRITEBACK: begin
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {line.tag, idx};
                if (!MEM_BUSYWAIT) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = miss_q;
                if (!MEM_BUSYWAIT) begin
                    state_nx = UPDATE;
                end
            end
            UPDATE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (idle) begin
            miss_q <= ADDRESS[ADDR_W-1:OFFSET_W];
        end
        if (state == FETCH && !MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that retires a request right after its fill is not a new
    // request, so it is excluded from the hit count.
    logic post_fill;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            post_fill  <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            post_fill <= (state == UPDATE);
            if (idle && req && hit && !post_fill
                && HIT_COUNT != 16'hFFFF) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (idle && state_nx != IDLE
                && MISS_COUNT != 16'hFFFF) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed self-checking bench for dcache_wb with a
// 5-cycle block memory model (one turnaround cycle after each transfer).
module tb_dcache_wb;

    localparam int TMEM = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dcache_wb dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT     (HIT_COUNT),
        .MISS_COUNT    (MISS_COUNT)
`endif
    );

    // Block memory: busy for TMEM-1 cycles, done on the TMEM-th,
    // then one turnaround cycle before a back-to-back transfer starts.
    logic [31:0] mem [64];
    int          mcnt = 0;
    logic        rec  = 1'b0;
    logic        mreq;

    assign mreq         = MEM_READ | MEM_WRITE;
    assign MEM_BUSYWAIT = mreq && (mcnt != TMEM - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'hC0DE0000 | 32'(i);
            end
            mem[6'h00] <= 32'h44332211;
            mem[6'h08] <= 32'hD4C3B2A1;
            mem[6'h09] <= 32'h99887766;
            mem[6'h11] <= 32'h87654321;
            mcnt <= 0;
            rec  <= 1'b0;
        end else if (mreq && !MEM_BUSYWAIT) begin
            mcnt <= 0;
            rec  <= 1'b1;
            if (MEM_WRITE) begin
                mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end
        end else begin
            rec <= 1'b0;
            if (!mreq) begin
                mcnt <= 0;
            end else if (!rec) begin
                mcnt <= mcnt + 1;
            end
        end
    end

    int          stalls;
    logic        rd_seen;
    logic        wr_seen;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Count cycles with BUSYWAIT high and note the first memory request
    // of each kind; called at a sample point with the request applied.
    task automatic wait_ready();
        stalls  = 0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        rd_addr = 'x;
        wr_addr = 'x;
        wr_data = 'x;
        while (BUSYWAIT && stalls < 200) begin
            stalls++;
            if (MEM_READ && !rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = MEM_ADDRESS;
            end
            if (MEM_WRITE && !wr_seen) begin
                wr_seen = 1'b1;
                wr_addr = MEM_ADDRESS;
                wr_data = MEM_WRITEDATA;
            end
            tick();
            #1;
        end
        check("wait_timeout", BUSYWAIT, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("rst_busywait", BUSYWAIT, 1'b0);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_mem_write", MEM_WRITE, 1'b0);
`ifdef DCACHE_STATS_EN
        check("rst_hits", HIT_COUNT, 16'd0);
        check("rst_misses", MISS_COUNT, 16'd0);
`endif

        // 1: cold read miss on 0x00
        tick();
        READ    = 1'b1;
        ADDRESS = 8'h00;
        #1;
        check("t1_busy_now", BUSYWAIT, 1'b1);
        wait_ready();
        check("t1_stalls", stalls, 7);
        check("t1_rd_seen", rd_seen, 1'b1);
        check("t1_rd_addr", rd_addr, 6'h00);
        check("t1_no_wb", wr_seen, 1'b0);
        check("t1_data", READDATA, 8'h11);

        // 2: read hit on 0x01
        tick();
        ADDRESS = 8'h01;
        #1;
        check("t2_busy", BUSYWAIT, 1'b0);
        check("t2_data", READDATA, 8'h22);
        check("t2_no_memrd", MEM_READ, 1'b0);
        tick();
        READ = 1'b0;
        #1;
        check("t2_rd_idle_zero", READDATA, 8'h00);
`ifdef DCACHE_STATS_EN
        check("t6_hits", HIT_COUNT, 16'd1);
        check("t6_misses", MISS_COUNT, 16'd1);
`endif

        // 3: write hit 0x02, then dirty conflict read 0x22
        WRITE     = 1'b1;
        ADDRESS   = 8'h02;
        WRITEDATA = 8'hAA;
        #1;
        check("t3_wr_busy", BUSYWAIT, 1'b0);
        tick();
        WRITE   = 1'b0;
        READ    = 1'b1;
        ADDRESS = 8'h22;
        #1;
        check("t3_busy_now", BUSYWAIT, 1'b1);
        wait_ready();
        check("t3_stalls", stalls, 13);
        check("t3_wb_seen", wr_seen, 1'b1);
        check("t3_wb_addr", wr_addr, 6'h00);
        check("t3_wb_data", wr_data, 32'h44AA2211);
        check("t3_rd_addr", rd_addr, 6'h08);
        check("t3_data", READDATA, 8'hC3);
        check("t3_mem_block", mem[6'h00], 32'h44AA2211);

        // 4: write miss on clean block 0x45
        tick();
        READ      = 1'b0;
        WRITE     = 1'b1;
        ADDRESS   = 8'h45;
        WRITEDATA = 8'h5C;
        #1;
        check("t4_busy_now", BUSYWAIT, 1'b1);
        wait_ready();
        check("t4_stalls", stalls, 7);
        check("t4_rd_addr", rd_addr, 6'h11);
        check("t4_no_wb", wr_seen, 1'b0);
        tick();
        WRITE = 1'b0;
        READ  = 1'b1;
        #1;
        check("t4_rd_busy", BUSYWAIT, 1'b0);
        check("t4_data", READDATA, 8'h5C);
        // evicting the block proves it was left dirty
        tick();
        ADDRESS = 8'h25;
        #1;
        check("t4_evict_busy", BUSYWAIT, 1'b1);
        wait_ready();
        check("t4_evict_stalls", stalls, 13);
        check("t4_wb_addr", wr_addr, 6'h11);
        check("t4_wb_data", wr_data, 32'h87655C21);
        check("t4_ev_rd_addr", rd_addr, 6'h09);
        check("t4_ev_data", READDATA, 8'h77);

        // 5: reset in the 3rd FETCH cycle
        tick();
        ADDRESS = 8'h61;
        #1;
        check("t5_busy_now", BUSYWAIT, 1'b1);
        tick();
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check("t5_fetching", MEM_READ, 1'b1);
        tick();
        RESET = 1'b0;
        READ  = 1'b0;
        #1;
        check("t5_memrd_off", MEM_READ, 1'b0);
        check("t5_busy_off", BUSYWAIT, 1'b0);
`ifdef DCACHE_STATS_EN
        check("t6_clr_hits", HIT_COUNT, 16'd0);
        check("t6_clr_misses", MISS_COUNT, 16'd0);
`endif
        tick();
        READ    = 1'b1;
        ADDRESS = 8'h01;
        #1;
        check("t5_miss_01", BUSYWAIT, 1'b1);
        wait_ready();
        check("t5_stalls", stalls, 7);
        check("t5_no_wb", wr_seen, 1'b0);
        check("t5_data", READDATA, 8'h22);
        tick();
        ADDRESS = 8'h25;
        #1;
        check("t5_miss_25", BUSYWAIT, 1'b1);
        wait_ready();
        check("t5_stalls_25", stalls, 7);
        check("t5_data_25", READDATA, 8'h77);
        tick();
        READ = 1'b0;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
